// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous memory between instruction fetch and data ports.
// Data wins ties; a run counter forces a fetch grant after MAX_DATA_RUN back-to-back data grants.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_writeb,
  output logic                d_gnt,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_read,
  output logic [DATA_W/8-1:0] mem_writeb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            state_q;
  logic [3:0]        run_q;
  logic [2:0]        cnt_q;
  logic              owner_data_q;
  logic              write_q;
  logic              ready_q;
  logic              mem_read_q;
  logic [BE_W-1:0]   mem_writeb_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic idle;
  logic data_pick;
  logic d_write;

  // Arbitration: grants only in IDLE and never while reset is asserted.
  always_comb begin
    idle      = (state_q == StIdle) && !reset;
    data_pick = d_req && (!if_req || (run_q != 4'(MAX_DATA_RUN)));
    d_write   = |d_writeb;
    d_gnt     = idle && data_pick;
    if_gnt    = idle && if_req && !data_pick;
  end

  // Controller: latch the granted request, issue it, count read latency, flag completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      run_q        <= 4'd0;
      cnt_q        <= 3'd0;
      owner_data_q <= 1'b0;
      write_q      <= 1'b0;
      ready_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_writeb_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      ready_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_writeb_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (d_gnt) begin
            state_q      <= StIssue;
            owner_data_q <= 1'b1;
            write_q      <= d_write;
            mem_addr_q   <= d_addr;
            mem_wdata_q  <= d_wdata;
            mem_read_q   <= !d_write;
            mem_writeb_q <= d_writeb;
            // Count data grants that starve a waiting fetch, saturating at 15.
            if (if_req) run_q <= (run_q == 4'hf) ? run_q : run_q + 4'd1;
            else        run_q <= 4'd0;
          end else if (if_gnt) begin
            state_q      <= StIssue;
            owner_data_q <= 1'b0;
            write_q      <= 1'b0;
            mem_addr_q   <= if_addr;
            mem_read_q   <= 1'b1;
            run_q        <= 4'd0;
          end
        end
        StIssue: begin
          if (write_q || (RD_LAT == 1)) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end else begin
            state_q <= StWait;
            cnt_q   <= 3'(RD_LAT - 1);
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs: memory strobes and ready pulses are suppressed in a reset cycle.
  always_comb begin
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
    mem_read   = mem_read_q && !reset;
    mem_writeb = mem_writeb_q & {BE_W{!reset}};
    busy       = (state_q != StIdle);
    if_ready   = ready_q && !owner_data_q && !reset;
    d_ready    = ready_q && owner_data_q && !reset;
    if_rdata   = if_ready ? mem_rdata : '0;
    d_rdata    = d_ready ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with RD_LAT=1, one with RD_LAT=3, shared inputs.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_writeb;
  logic [31:0] mem_rdata;

  logic        if_gnt, if_ready, d_gnt, d_ready, mem_read, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_writeb;

  logic        if_gnt3, if_ready3, d_gnt3, d_ready3, mem_read3, busy3;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3;
  logic [3:0]  mem_writeb3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.RD_LAT(1), .MAX_DATA_RUN(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_ready(if_ready),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_writeb(d_writeb),
    .d_gnt(d_gnt), .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_writeb(mem_writeb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.RD_LAT(3), .MAX_DATA_RUN(4)) dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3), .if_ready(if_ready3),
    .if_rdata(if_rdata3),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_writeb(d_writeb),
    .d_gnt(d_gnt3), .d_ready(d_ready3), .d_rdata(d_rdata3),
    .mem_addr(mem_addr3), .mem_read(mem_read3), .mem_writeb(mem_writeb3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; inputs are then driven at +2 and outputs sampled at +3.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_addr = '0;
    d_wdata = '0; d_writeb = '0; mem_rdata = '0;

    // Reset with no requests: everything quiet.
    tick(); tick();
    reset = 1'b0;
    tick(); #1;
    check("rst_if_gnt", 32'(if_gnt), 0);
    check("rst_d_gnt", 32'(d_gnt), 0);
    check("rst_if_ready", 32'(if_ready), 0);
    check("rst_d_ready", 32'(d_ready), 0);
    check("rst_mem_read", 32'(mem_read), 0);
    check("rst_mem_writeb", 32'(mem_writeb), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_mem_addr", mem_addr, 0);

    // Single fetch read, RD_LAT=1.
    mem_rdata = 32'h0000_0013;
    if_req = 1'b1; if_addr = 32'h100; #1;
    check("f_if_gnt", 32'(if_gnt), 1);
    check("f_d_gnt", 32'(d_gnt), 0);
    tick(); if_req = 1'b0; #1;
    check("f_mem_read", 32'(mem_read), 1);
    check("f_mem_addr", mem_addr, 32'h100);
    check("f_busy", 32'(busy), 1);
    check("f_if_ready_early", 32'(if_ready), 0);
    tick(); #1;
    check("f_if_ready", 32'(if_ready), 1);
    check("f_if_rdata", if_rdata, 32'h13);
    check("f_mem_read_off", 32'(mem_read), 0);
    tick(); #1;
    check("f_if_ready_pulse", 32'(if_ready), 0);
    check("f_if_rdata_zero", if_rdata, 0);

    // Data write.
    d_req = 1'b1; d_addr = 32'h200; d_wdata = 32'hdeadbeef; d_writeb = 4'b0011; #1;
    check("w_d_gnt", 32'(d_gnt), 1);
    tick(); d_req = 1'b0; #1;
    check("w_mem_writeb", 32'(mem_writeb), 32'h3);
    check("w_mem_read", 32'(mem_read), 0);
    check("w_mem_addr", mem_addr, 32'h200);
    check("w_mem_wdata", mem_wdata, 32'hdeadbeef);
    tick(); #1;
    check("w_d_ready", 32'(d_ready), 1);
    check("w_mem_writeb_off", 32'(mem_writeb), 0);
    check("w_mem_read_off", 32'(mem_read), 0);
    tick(); #1;
    check("w_d_ready_pulse", 32'(d_ready), 0);

    // Simultaneous fetch and data read: data first, fetch granted in the d_ready cycle.
    mem_rdata = 32'h1234_5678;
    if_req = 1'b1; if_addr = 32'h104; d_req = 1'b1; d_addr = 32'h300; d_writeb = 4'b0; #1;
    check("c_d_gnt", 32'(d_gnt), 1);
    check("c_if_gnt", 32'(if_gnt), 0);
    tick(); d_req = 1'b0; #1;
    check("c_if_gnt_busy", 32'(if_gnt), 0);
    check("c_mem_addr_d", mem_addr, 32'h300);
    tick(); #1;
    check("c_d_ready", 32'(d_ready), 1);
    check("c_d_rdata", d_rdata, 32'h1234_5678);
    check("c_if_gnt_b2b", 32'(if_gnt), 1);
    tick(); if_req = 1'b0; #1;
    check("c_mem_addr_f", mem_addr, 32'h104);
    check("c_mem_read_f", 32'(mem_read), 1);
    tick(); #1;
    check("c_if_ready", 32'(if_ready), 1);
    tick();

    // Forward progress: four data grants, then fetch, then data resumes.
    reset = 1'b1; tick(); reset = 1'b0;
    if_req = 1'b1; d_req = 1'b1; d_writeb = 4'b0;
    for (int k = 0; k < 6; k++) begin
      logic exp_d;
      exp_d = (k != 4);
      #1;
      check($sformatf("run_d_gnt_%0d", k), 32'(d_gnt), 32'(exp_d));
      check($sformatf("run_if_gnt_%0d", k), 32'(if_gnt), 32'(!exp_d));
      tick(); tick();
    end
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick();

    // RD_LAT=3 read on the second instance.
    reset = 1'b1; tick(); reset = 1'b0;
    mem_rdata = 32'hcafef00d;
    d_req = 1'b1; d_addr = 32'h400; d_writeb = 4'b0; #1;
    check("l3_d_gnt", 32'(d_gnt3), 1);
    tick(); d_req = 1'b0; #1;
    check("l3_mem_read", 32'(mem_read3), 1);
    tick(); #1;
    check("l3_busy_t2", 32'(busy3), 1);
    check("l3_d_ready_t2", 32'(d_ready3), 0);
    tick(); #1;
    check("l3_d_ready_t3", 32'(d_ready3), 0);
    check("l3_mem_read_t3", 32'(mem_read3), 0);
    tick(); #1;
    check("l3_d_ready_t4", 32'(d_ready3), 1);
    check("l3_d_rdata", d_rdata3, 32'hcafef00d);
    tick(); #1;
    check("l3_d_ready_pulse", 32'(d_ready3), 0);
    check("l3_busy_done", 32'(busy3), 0);

    // Reset landing on the ISSUE cycle of a write.
    d_req = 1'b1; d_addr = 32'h500; d_wdata = 32'h55aa55aa; d_writeb = 4'hf; #1;
    check("rw_d_gnt", 32'(d_gnt), 1);
    tick(); d_req = 1'b0; reset = 1'b1; #1;
    check("rw_mem_writeb", 32'(mem_writeb), 0);
    check("rw_d_ready_rst", 32'(d_ready), 0);
    check("rw_d_gnt_rst", 32'(d_gnt), 0);
    tick(); reset = 1'b0; #1;
    check("rw_busy", 32'(busy), 0);
    check("rw_d_ready", 32'(d_ready), 0);
    check("rw_mem_addr", mem_addr, 0);
    check("rw_mem_wdata", mem_wdata, 0);
    tick(); #1;
    check("rw_d_ready_late", 32'(d_ready), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
